// File: rtl/maze_map_buffer.sv
// rtl/maze_map_buffer.sv - double-buffered maze cell map with frame-synchronous publish
// Writes land in a shadow map; a COMMIT publishes the whole shadow to the display map at the next FRAME_START.
module maze_map_buffer #(
  parameter int                ROWS       = 5,
  parameter int                COLS       = 4,
  parameter int                CELL_W     = 8,
  parameter logic [CELL_W-1:0] RESET_CELL = 8'h0F,
  parameter int                HEARTBEAT  = 25000000,
  localparam int               RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int               CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [RW-1:0]     WR_ROW,
  input  logic [CW-1:0]     WR_COL,
  input  logic [CELL_W-1:0] WR_DATA,
  input  logic              COMMIT,
  input  logic              FRAME_START,
  input  logic [RW-1:0]     RD_ROW,
  input  logic [CW-1:0]     RD_COL,
  output logic [CELL_W-1:0] RD_DATA,
  output logic              PENDING,
  output logic [7:0]        FRAME_CNT,
  output logic              ERR_ADDR,
  output logic              LED_HB
);

  localparam int HB_W = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_COPY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              wr_ready_q, wr_ready_d;
  logic              pending_q, pending_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              err_addr_q, err_addr_d;
  logic              led_hb_q, led_hb_d;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic [CELL_W-1:0] rd_data_q, rd_data_d;
  logic [CELL_W-1:0] shadow_q [ROWS][COLS];
  logic [CELL_W-1:0] shadow_d [ROWS][COLS];
  logic [CELL_W-1:0] active_q [ROWS][COLS];
  logic [CELL_W-1:0] active_d [ROWS][COLS];

  logic wr_fire;
  logic wr_in_range;
  logic rd_in_range;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    frame_cnt_d = frame_cnt_q;
    err_addr_d  = err_addr_q;
    rd_data_d   = RESET_CELL;
    hb_cnt_d    = hb_cnt_q + HB_W'(1);
    led_hb_d    = led_hb_q;

    wr_fire     = WR_VALID && wr_ready_q;
    wr_in_range = (int'(WR_ROW) < ROWS) && (int'(WR_COL) < COLS);
    rd_in_range = (int'(RD_ROW) < ROWS) && (int'(RD_COL) < COLS);

    // Ready is only high in IDLE, so a handshake can never race the copy.
    if (wr_fire) begin
      if (wr_in_range) begin
        shadow_d[WR_ROW][WR_COL] = WR_DATA;
      end else begin
        err_addr_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (COMMIT) state_d = S_PEND;
      S_PEND: if (FRAME_START) state_d = S_COPY;
      S_COPY: begin
        active_d    = shadow_q;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ready_d = (state_d == S_IDLE);
    pending_d  = (state_d != S_IDLE);

    // Read samples the pre-edge active map, so a read during COPY sees old data.
    if (rd_in_range) begin
      rd_data_d = active_q[RD_ROW][RD_COL];
    end

    if (hb_cnt_q == HB_W'(HEARTBEAT - 1)) begin
      hb_cnt_d = '0;
      led_hb_d = ~led_hb_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      wr_ready_q  <= 1'b1;
      pending_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      err_addr_q  <= 1'b0;
      led_hb_q    <= 1'b0;
      hb_cnt_q    <= '0;
      rd_data_q   <= RESET_CELL;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          shadow_q[r][c] <= RESET_CELL;
          active_q[r][c] <= RESET_CELL;
        end
      end
    end else begin
      state_q     <= state_d;
      wr_ready_q  <= wr_ready_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      err_addr_q  <= err_addr_d;
      led_hb_q    <= led_hb_d;
      hb_cnt_q    <= hb_cnt_d;
      rd_data_q   <= rd_data_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  assign WR_READY  = wr_ready_q;
  assign PENDING   = pending_q;
  assign FRAME_CNT = frame_cnt_q;
  assign ERR_ADDR  = err_addr_q;
  assign LED_HB    = led_hb_q;
  assign RD_DATA   = rd_data_q;

endmodule
